// File: rtl/id_ex_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_pkg
// Shared definitions for the Decode -> Execute boundary:
//   - default field widths (operand/PC, register index, shifter operand)
//   - NZCV bit positions inside the status register
//   - 4-bit condition-field encodings and ALU opcode constants
//   - decode_bundle_t: the decoded-instruction record that Decode produces
//     and the ID/EX register holds
//   - ctl_gate(): squashes side-effect controls of bubbles / failed conditions
// -----------------------------------------------------------------------------
package id_ex_stage_reg_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_W   = 4;
  localparam int DEF_SHIFT_W = 12;

  // Bit positions inside sr = {N,Z,C,V}
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Decoded instruction: control bits first, then datapath fields.
  typedef struct packed {
    logic [3:0]             cond;
    logic [3:0]             opcode;
    logic                   s;
    logic                   wb_en;
    logic                   mem_r;
    logic                   mem_w;
    logic                   b;
    logic                   imm;
    logic [DEF_SHIFT_W-1:0] shift_op;
    logic [23:0]            imm24;
    logic [DEF_DATA_W-1:0]  val_rn;
    logic [DEF_DATA_W-1:0]  val_rm;
    logic [DEF_REG_W-1:0]   dest;
    logic [DEF_DATA_W-1:0]  pc;
  } decode_bundle_t;

  // A side-effect control only fires for a real instruction whose
  // condition passed.
  function automatic logic [3:0] ctl_gate(input logic [3:0] raw,
                                          input logic       valid,
                                          input logic       check);
    return raw & {4{valid & check}};
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bundle of all Decode-side inputs, the condition-check / ALU feedback, and
// the Execute-side outputs of the ID/EX pipeline register.
//   master : Decode + hazard/branch control + condition check + ALU side
//            (drives stall, flush, id_*, check, alu_sr; observes ex_*, sr)
//   slave  : the ID/EX stage register itself
// Parameters: DATA_W (operands/PC), REG_W (register index), SHIFT_W (shifter
// operand). Defaults match the shared decode_bundle_t widths.
// -----------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
  parameter int DATA_W  = id_ex_stage_reg_pkg::DEF_DATA_W,
  parameter int REG_W   = id_ex_stage_reg_pkg::DEF_REG_W,
  parameter int SHIFT_W = id_ex_stage_reg_pkg::DEF_SHIFT_W
);

  // Pipeline control
  logic               stall;
  logic               flush;

  // Decode side
  logic               id_valid;
  logic [DATA_W-1:0]  id_pc;
  logic [3:0]         id_cond;
  logic [3:0]         id_opcode;
  logic               id_s;
  logic               id_wb_en;
  logic               id_mem_r;
  logic               id_mem_w;
  logic               id_b;
  logic               id_imm;
  logic [SHIFT_W-1:0] id_shift_op;
  logic [23:0]        id_imm24;
  logic [DATA_W-1:0]  id_val_rn;
  logic [DATA_W-1:0]  id_val_rm;
  logic [REG_W-1:0]   id_dest;

  // Feedback from condition check and ALU
  logic               check;
  logic [3:0]         alu_sr;

  // Execute side
  logic [3:0]         ex_cond;
  logic [3:0]         sr;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc;
  logic [3:0]         ex_opcode;
  logic               ex_s;
  logic               ex_imm;
  logic [SHIFT_W-1:0] ex_shift_op;
  logic [23:0]        ex_imm24;
  logic [DATA_W-1:0]  ex_val_rn;
  logic [DATA_W-1:0]  ex_val_rm;
  logic [REG_W-1:0]   ex_dest;
  logic               ex_wb_en;
  logic               ex_mem_r;
  logic               ex_mem_w;
  logic               ex_b;
  logic               ex_carry;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_cond, id_opcode, id_s, id_wb_en, id_mem_r,
           id_mem_w, id_b, id_imm, id_shift_op, id_imm24, id_val_rn,
           id_val_rm, id_dest,
    output check, alu_sr,
    input  ex_cond, sr, ex_valid, ex_pc, ex_opcode, ex_s, ex_imm,
           ex_shift_op, ex_imm24, ex_val_rn, ex_val_rm, ex_dest,
           ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_carry
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_cond, id_opcode, id_s, id_wb_en, id_mem_r,
           id_mem_w, id_b, id_imm, id_shift_op, id_imm24, id_val_rn,
           id_val_rm, id_dest,
    input  check, alu_sr,
    output ex_cond, sr, ex_valid, ex_pc, ex_opcode, ex_s, ex_imm,
           ex_shift_op, ex_imm24, ex_val_rn, ex_val_rm, ex_dest,
           ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_carry
  );

endinterface

// File: rtl/id_ex_stage_reg_status_reg.sv
// -----------------------------------------------------------------------------
// status_reg
// Architectural NZCV status register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears to 0000)
//   i_ex_valid  : EX holds a real instruction
//   i_ex_s      : EX instruction requests a flag update
//   i_check     : EX instruction's condition passed
//   i_stall     : EX is being held this cycle
//   i_alu_sr    : NZCV produced by the ALU for the EX instruction
//   o_sr        : current {N,Z,C,V}
// -----------------------------------------------------------------------------
module status_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ex_valid,
  input  logic       i_ex_s,
  input  logic       i_check,
  input  logic       i_stall,
  input  logic [3:0] i_alu_sr,
  output logic [3:0] o_sr
);

  logic [3:0] r_sr;
  logic       w_upd_en;

  // A stalled instruction stays in EX for another cycle, so committing its
  // flags now would write them twice. Flush is deliberately absent: it
  // only affects what enters EX, while the departing instruction commits.
  assign w_upd_en = i_ex_valid & i_ex_s & i_check & ~i_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'b0000;
    end else if (w_upd_en) begin
      r_sr <= i_alu_sr;
    end
  end

  assign o_sr = r_sr;

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// Decode -> Execute pipeline register with the NZCV status register.
// Ports:
//   clk    : clock, rising-edge
//   rst_n  : asynchronous active-low reset; clears every field and sr
//   bus    : id_ex_stage_reg_if.slave
//            in : stall, flush, id_* decoded fields, check, alu_sr
//            out: ex_* registered fields, sr, ex_carry, and the effective
//                 controls ex_wb_en/ex_mem_r/ex_mem_w/ex_b which are gated
//                 by ex_valid and check
// Update priority on each edge: flush (load all-zero bubble) > stall (hold)
// > load from Decode.
// -----------------------------------------------------------------------------
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  id_ex_stage_reg_if.slave bus
);

  decode_bundle_t r_ex;
  decode_bundle_t w_id;
  decode_bundle_t w_ex_next;
  logic           r_ex_valid;
  logic           w_ex_valid_next;
  logic [3:0]     w_sr;
  logic [3:0]     w_ctl_eff;

  always_comb begin
    w_id          = '0;
    w_id.cond     = bus.id_cond;
    w_id.opcode   = bus.id_opcode;
    w_id.s        = bus.id_s;
    w_id.wb_en    = bus.id_wb_en;
    w_id.mem_r    = bus.id_mem_r;
    w_id.mem_w    = bus.id_mem_w;
    w_id.b        = bus.id_b;
    w_id.imm      = bus.id_imm;
    w_id.shift_op = bus.id_shift_op;
    w_id.imm24    = bus.id_imm24;
    w_id.val_rn   = bus.id_val_rn;
    w_id.val_rm   = bus.id_val_rm;
    w_id.dest     = bus.id_dest;
    w_id.pc       = bus.id_pc;
  end

  // A bubble is all-zero (including cond) so nothing stale leaks into EX.
  // An id_valid=0 load still captures the fields; ex_valid keeps them inert.
  always_comb begin
    w_ex_next       = r_ex;
    w_ex_valid_next = r_ex_valid;
    if (bus.flush) begin
      w_ex_next       = '0;
      w_ex_valid_next = 1'b0;
    end else if (!bus.stall) begin
      w_ex_next       = w_id;
      w_ex_valid_next = bus.id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      r_ex       <= w_ex_next;
      r_ex_valid <= w_ex_valid_next;
    end
  end

  status_reg u_status_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ex_valid (r_ex_valid),
    .i_ex_s     (r_ex.s),
    .i_check    (bus.check),
    .i_stall    (bus.stall),
    .i_alu_sr   (bus.alu_sr),
    .o_sr       (w_sr)
  );

  // Effective controls are combinational so a late check result squashes
  // writeback / memory / branch within the same cycle.
  assign w_ctl_eff = ctl_gate({r_ex.wb_en, r_ex.mem_r, r_ex.mem_w, r_ex.b},
                              r_ex_valid, bus.check);

  assign bus.ex_wb_en    = w_ctl_eff[3];
  assign bus.ex_mem_r    = w_ctl_eff[2];
  assign bus.ex_mem_w    = w_ctl_eff[1];
  assign bus.ex_b        = w_ctl_eff[0];

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_cond     = r_ex.cond;
  assign bus.ex_opcode   = r_ex.opcode;
  assign bus.ex_s        = r_ex.s;
  assign bus.ex_imm      = r_ex.imm;
  assign bus.ex_shift_op = r_ex.shift_op;
  assign bus.ex_imm24    = r_ex.imm24;
  assign bus.ex_val_rn   = r_ex.val_rn;
  assign bus.ex_val_rm   = r_ex.val_rm;
  assign bus.ex_dest     = r_ex.dest;
  assign bus.ex_pc       = r_ex.pc;

  assign bus.sr          = w_sr;
  assign bus.ex_carry    = w_sr[SR_C];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Self-checking bench: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the ID/EX register and status flags.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] imm24;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [31:0] pc;
  } tb_instr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_reg_if bus_if ();

  id_ex_stage_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what EX should hold, whether it is real, and the flags.
  tb_instr_t  cur_id;
  logic       cur_valid;
  tb_instr_t  m_ex;
  logic       m_valid;
  logic [3:0] m_sr;

  function automatic logic [145:0] dp_of(input tb_instr_t t);
    return {t.cond, t.opcode, t.s, t.imm, t.shift_op, t.imm24,
            t.rn, t.rm, t.dest, t.pc};
  endfunction

  function automatic logic [145:0] obs_dp();
    return {bus_if.ex_cond, bus_if.ex_opcode, bus_if.ex_s, bus_if.ex_imm,
            bus_if.ex_shift_op, bus_if.ex_imm24, bus_if.ex_val_rn,
            bus_if.ex_val_rm, bus_if.ex_dest, bus_if.ex_pc};
  endfunction

  function automatic logic [3:0] obs_ctl();
    return {bus_if.ex_wb_en, bus_if.ex_mem_r, bus_if.ex_mem_w, bus_if.ex_b};
  endfunction

  function automatic logic [3:0] exp_ctl();
    if (m_valid && bus_if.check)
      return {m_ex.wb, m_ex.mr, m_ex.mw, m_ex.b};
    return 4'b0000;
  endfunction

  task automatic rand_instr(output tb_instr_t t);
    t.cond     = 4'($urandom);
    t.opcode   = 4'($urandom);
    t.s        = 1'($urandom);
    t.wb       = 1'($urandom);
    t.mr       = 1'($urandom);
    t.mw       = 1'($urandom);
    t.b        = 1'($urandom);
    t.imm      = 1'($urandom);
    t.shift_op = 12'($urandom);
    t.imm24    = 24'($urandom);
    t.rn       = $urandom;
    t.rm       = $urandom;
    t.dest     = 4'($urandom);
    t.pc       = $urandom;
  endtask

  task automatic drive_id(input tb_instr_t t, input logic v);
    cur_id             = t;
    cur_valid          = v;
    bus_if.id_valid    = v;
    bus_if.id_cond     = t.cond;
    bus_if.id_opcode   = t.opcode;
    bus_if.id_s        = t.s;
    bus_if.id_wb_en    = t.wb;
    bus_if.id_mem_r    = t.mr;
    bus_if.id_mem_w    = t.mw;
    bus_if.id_b        = t.b;
    bus_if.id_imm      = t.imm;
    bus_if.id_shift_op = t.shift_op;
    bus_if.id_imm24    = t.imm24;
    bus_if.id_val_rn   = t.rn;
    bus_if.id_val_rm   = t.rm;
    bus_if.id_dest     = t.dest;
    bus_if.id_pc       = t.pc;
  endtask

  task automatic model_reset();
    m_ex    = '0;
    m_valid = 1'b0;
    m_sr    = 4'b0000;
  endtask

  // One clock: the departing instruction commits flags unless held, then
  // the register takes a bubble, holds, or takes Decode's instruction.
  task automatic step();
    if (m_valid && m_ex.s && bus_if.check && !bus_if.stall)
      m_sr = bus_if.alu_sr;
    if (bus_if.flush) begin
      m_ex    = '0;
      m_valid = 1'b0;
    end else if (!bus_if.stall) begin
      m_ex    = cur_id;
      m_valid = cur_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tb_instr_t t;
    rst_n = 1'b0;
    model_reset();
    bus_if.check = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr(t);
      drive_id(t, 1'b1);
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_if.ex_valid !== 1'b0 || bus_if.sr !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state: ex_valid=%b sr=%b, required 0 and 0000",
                 bus_if.ex_valid, bus_if.sr);
      end
      n_tests++;
      if (obs_dp() !== 146'd0 || obs_ctl() !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_fields: dp=%h ctl=%b, required all zero",
                 obs_dp(), obs_ctl());
      end
    end
    rst_n = 1'b1;
    rand_instr(t);
    t.dest = 4'd5;
    drive_id(t, 1'b1);
    step();
    n_tests++;
    if (bus_if.ex_dest !== 4'd5 || bus_if.ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_load: ex_dest=%0d ex_valid=%b, required 5 and 1",
               bus_if.ex_dest, bus_if.ex_valid);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_squash();
    tb_instr_t t;
    rand_instr(t);
    t.wb = 1'b1;
    t.mw = 1'b1;
    bus_if.check = 1'b0;
    drive_id(t, 1'b1);
    step();
    n_tests++;
    if (bus_if.ex_wb_en !== 1'b0 || bus_if.ex_mem_w !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_fail: wb=%b mem_w=%b, required 0 0",
               bus_if.ex_wb_en, bus_if.ex_mem_w);
    end
    bus_if.check = 1'b1;
    #1;
    n_tests++;
    if (bus_if.ex_wb_en !== 1'b1 || bus_if.ex_mem_w !== 1'b1) begin
      n_fail++;
      $display("FAIL squash_pass: wb=%b mem_w=%b, required 1 1",
               bus_if.ex_wb_en, bus_if.ex_mem_w);
    end
    bus_if.check = 1'b0;
    $display("[TB] condition squash: done");
  endtask

  task automatic test_flags();
    tb_instr_t t;
    rand_instr(t);
    t.s = 1'b1;
    bus_if.check = 1'b0;
    drive_id(t, 1'b1);
    step();
    bus_if.check  = 1'b1;
    bus_if.alu_sr = 4'b1010;
    rand_instr(t);
    drive_id(t, 1'b0);
    step();
    n_tests++;
    if (bus_if.sr !== 4'b1010 || bus_if.ex_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_update: sr=%b carry=%b, required 1010 1",
               bus_if.sr, bus_if.ex_carry);
    end
    rand_instr(t);
    t.s = 1'b1;
    bus_if.check = 1'b0;
    drive_id(t, 1'b1);
    step();
    bus_if.alu_sr = 4'b0101;
    rand_instr(t);
    drive_id(t, 1'b0);
    step();
    n_tests++;
    if (bus_if.sr !== 4'b1010) begin
      n_fail++;
      $display("FAIL flag_check0: sr=%b, required 1010", bus_if.sr);
    end
    $display("[TB] flag update: done");
  endtask

  task automatic test_stall();
    tb_instr_t a;
    tb_instr_t t;
    logic [3:0] sr_hold;
    rand_instr(a);
    a.s = 1'b1;
    bus_if.check = 1'b0;
    drive_id(a, 1'b1);
    step();
    sr_hold       = m_sr;
    bus_if.stall  = 1'b1;
    bus_if.check  = 1'b1;
    bus_if.alu_sr = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      rand_instr(t);
      drive_id(t, 1'($urandom));
      step();
      n_tests++;
      if (obs_dp() !== dp_of(a) || bus_if.ex_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: dp=%h valid=%b, required %h 1",
                 obs_dp(), bus_if.ex_valid, dp_of(a));
      end
      n_tests++;
      if (bus_if.sr !== sr_hold) begin
        n_fail++;
        $display("FAIL stall_sr: sr=%b, required %b", bus_if.sr, sr_hold);
      end
    end
    bus_if.stall = 1'b0;
    rand_instr(t);
    drive_id(t, 1'b1);
    step();
    n_tests++;
    if (bus_if.sr !== 4'b0100 || obs_dp() !== dp_of(t)) begin
      n_fail++;
      $display("FAIL stall_release: sr=%b dp=%h, required 0100 %h",
               bus_if.sr, obs_dp(), dp_of(t));
    end
    bus_if.check = 1'b0;
    $display("[TB] stall: done");
  endtask

  task automatic test_flush();
    tb_instr_t t;
    logic [3:0] sr_before;
    logic       st;
    for (int k = 0; k < 2; k++) begin
      st = (k == 0);
      rand_instr(t);
      t.s = 1'b1;
      bus_if.check = 1'b0;
      bus_if.stall = 1'b0;
      bus_if.flush = 1'b0;
      drive_id(t, 1'b1);
      step();
      sr_before     = m_sr;
      bus_if.flush  = 1'b1;
      bus_if.stall  = st;
      bus_if.check  = 1'b1;
      bus_if.alu_sr = 4'b0001;
      rand_instr(t);
      drive_id(t, 1'b1);
      step();
      n_tests++;
      if (bus_if.ex_valid !== 1'b0 || obs_ctl() !== 4'b0000 ||
          obs_dp() !== 146'd0) begin
        n_fail++;
        $display("FAIL flush_bubble(stall=%b): valid=%b ctl=%b dp=%h, required 0 0000 0",
                 st, bus_if.ex_valid, obs_ctl(), obs_dp());
      end
      n_tests++;
      if (bus_if.sr !== (st ? sr_before : 4'b0001)) begin
        n_fail++;
        $display("FAIL flush_sr(stall=%b): sr=%b, required %b",
                 st, bus_if.sr, st ? sr_before : 4'b0001);
      end
    end
    bus_if.flush = 1'b0;
    bus_if.stall = 1'b0;
    bus_if.check = 1'b0;
    $display("[TB] flush vs stall: done");
  endtask

  task automatic test_async_reset();
    tb_instr_t t;
    rand_instr(t);
    t.s = 1'b1;
    bus_if.check = 1'b0;
    drive_id(t, 1'b1);
    step();
    bus_if.check  = 1'b1;
    bus_if.alu_sr = 4'b1111;
    step();
    n_tests++;
    if (bus_if.sr !== 4'b1111 || bus_if.ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: sr=%b valid=%b, required 1111 1",
               bus_if.sr, bus_if.ex_valid);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus_if.sr !== 4'b0000 || bus_if.ex_valid !== 1'b0 ||
        obs_dp() !== 146'd0) begin
      n_fail++;
      $display("FAIL async_reset: sr=%b valid=%b dp=%h, required 0000 0 0",
               bus_if.sr, bus_if.ex_valid, obs_dp());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.check = 1'b0;
    $display("[TB] async reset: done");
  endtask

  task automatic test_random();
    tb_instr_t t;
    for (int i = 0; i < 300; i++) begin
      bus_if.stall  = ($urandom_range(0, 3) == 0);
      bus_if.flush  = ($urandom_range(0, 7) == 0);
      bus_if.check  = 1'($urandom);
      bus_if.alu_sr = 4'($urandom);
      rand_instr(t);
      drive_id(t, 1'($urandom));
      step();
      n_tests++;
      if (obs_dp() !== dp_of(m_ex) || bus_if.ex_valid !== m_valid) begin
        n_fail++;
        $display("FAIL rand_fields[%0d]: dp=%h valid=%b, required %h %b",
                 i, obs_dp(), bus_if.ex_valid, dp_of(m_ex), m_valid);
      end
      n_tests++;
      if (obs_ctl() !== exp_ctl()) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: ctl=%b, required %b",
                 i, obs_ctl(), exp_ctl());
      end
      n_tests++;
      if (bus_if.sr !== m_sr || bus_if.ex_carry !== m_sr[1]) begin
        n_fail++;
        $display("FAIL rand_sr[%0d]: sr=%b carry=%b, required %b %b",
                 i, bus_if.sr, bus_if.ex_carry, m_sr, m_sr[1]);
      end
    end
    bus_if.stall = 1'b0;
    bus_if.flush = 1'b0;
    $display("[TB] randomized run: done");
  endtask

  initial begin
    tb_instr_t t0;
    t0 = '0;
    bus_if.stall  = 1'b0;
    bus_if.flush  = 1'b0;
    bus_if.check  = 1'b0;
    bus_if.alu_sr = 4'b0000;
    drive_id(t0, 1'b0);
    model_reset();
    test_reset();
    test_squash();
    test_flags();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
